// File: rtl/assoc_lru_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : assoc_lru_buffer
//  Description : Fully associative key/data store with true-LRU replacement,
//                delete and a one-entry-per-cycle flush sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module assoc_lru_buffer #(
    parameter int KEY_W  = 4,
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4,
    localparam int AGE_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              async_nreset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [KEY_W-1:0]  req_key,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    output logic              rsp_hit,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_evict,
    output logic [KEY_W-1:0]  rsp_evict_key,
    output logic [CNT_W-1:0]  count
);

    localparam logic [2:0] c_OP_READ   = 3'd1;
    localparam logic [2:0] c_OP_WRITE  = 3'd2;
    localparam logic [2:0] c_OP_INCR   = 3'd3;
    localparam logic [2:0] c_OP_DELETE = 3'd4;
    localparam logic [2:0] c_OP_FLUSH  = 3'd5;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [AGE_W-1:0]    r_flush_idx;

    logic [DEPTH-1:0]    r_valid;
    logic [KEY_W-1:0]    r_key  [DEPTH];
    logic [DATA_W-1:0]   r_data [DEPTH];
    logic [AGE_W-1:0]    r_age  [DEPTH];
    logic [CNT_W-1:0]    r_count;

    logic                r_rsp_valid;
    logic                r_rsp_hit;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_rsp_evict;
    logic [KEY_W-1:0]    r_rsp_evict_key;

    logic                w_accept;
    logic                w_hit;
    logic [AGE_W-1:0]    w_hit_idx;
    logic [AGE_W-1:0]    w_hit_age;
    logic [DATA_W-1:0]   w_hit_data;
    logic                w_free_found;
    logic [AGE_W-1:0]    w_free_idx;
    logic [AGE_W-1:0]    w_victim_idx;
    logic                w_full;
    logic [AGE_W-1:0]    w_slot;
    logic                w_is_rw;
    logic                w_touch;
    logic                w_insert;
    logic                w_evict;
    logic                w_delete;
    logic                w_flush_last;

    // Ready is forced low while reset is held, even though the FSM sits in IDLE.
    assign req_ready    = (r_state == ST_IDLE) && async_nreset;
    assign w_accept     = req_valid && req_ready;
    assign w_full       = (r_count == CNT_W'(DEPTH));
    assign w_slot       = w_full ? w_victim_idx : w_free_idx;
    assign w_is_rw      = (req_op == c_OP_WRITE) || (req_op == c_OP_INCR);
    assign w_touch      = w_accept && w_hit && (w_is_rw || (req_op == c_OP_READ));
    assign w_insert     = w_accept && !w_hit && w_is_rw;
    assign w_evict      = w_insert && w_full;
    assign w_delete     = w_accept && w_hit && (req_op == c_OP_DELETE);
    assign w_flush_last = (r_state == ST_FLUSH) && (r_flush_idx == AGE_W'(DEPTH - 1));

    // Lookup, lowest free slot and LRU victim search.
    always_comb begin
        w_hit        = 1'b0;
        w_hit_idx    = '0;
        w_hit_age    = '0;
        w_hit_data   = '0;
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_victim_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_key[i] == req_key) && !w_hit) begin
                w_hit      = 1'b1;
                w_hit_idx  = AGE_W'(i);
                w_hit_age  = r_age[i];
                w_hit_data = r_data[i];
            end
            if (!r_valid[i] && !w_free_found) begin
                w_free_found = 1'b1;
                w_free_idx   = AGE_W'(i);
            end
            if (r_valid[i] && (r_age[i] == AGE_W'(DEPTH - 1))) begin
                w_victim_idx = AGE_W'(i);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept && (req_op == c_OP_FLUSH)) w_state_next = ST_FLUSH;
            ST_FLUSH: if (w_flush_last) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            r_state     <= ST_IDLE;
            r_flush_idx <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_FLUSH) begin
                r_flush_idx <= w_flush_last ? '0 : r_flush_idx + AGE_W'(1);
            end else begin
                r_flush_idx <= '0;
            end
        end
    end

    // Entry storage and age bookkeeping; at most one update kind applies per cycle.
    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_key[i]  <= '0;
                r_data[i] <= '0;
                r_age[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_state == ST_FLUSH) begin
                    if (r_flush_idx == AGE_W'(i)) begin
                        r_valid[i] <= 1'b0;
                        r_key[i]   <= '0;
                        r_data[i]  <= '0;
                        r_age[i]   <= '0;
                    end
                end else if (w_touch) begin
                    if (w_hit_idx == AGE_W'(i)) begin
                        r_age[i] <= '0;
                        if (req_op == c_OP_WRITE) begin
                            r_data[i] <= req_data;
                        end else if (req_op == c_OP_INCR) begin
                            r_data[i] <= r_data[i] + DATA_W'(1);
                        end
                    end else if (r_valid[i] && (r_age[i] < w_hit_age)) begin
                        r_age[i] <= r_age[i] + AGE_W'(1);
                    end
                end else if (w_insert) begin
                    if (w_slot == AGE_W'(i)) begin
                        r_valid[i] <= 1'b1;
                        r_key[i]   <= req_key;
                        r_data[i]  <= req_data;
                        r_age[i]   <= '0;
                    end else if (r_valid[i]) begin
                        r_age[i] <= r_age[i] + AGE_W'(1);
                    end
                end else if (w_delete) begin
                    if (w_hit_idx == AGE_W'(i)) begin
                        r_valid[i] <= 1'b0;
                        r_age[i]   <= '0;
                    end else if (r_valid[i] && (r_age[i] > w_hit_age)) begin
                        r_age[i] <= r_age[i] - AGE_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            r_count <= '0;
        end else if (r_state == ST_FLUSH) begin
            if (w_flush_last) begin
                r_count <= '0;
            end else if (r_valid[r_flush_idx]) begin
                r_count <= r_count - CNT_W'(1);
            end
        end else if (w_insert && !w_full) begin
            r_count <= r_count + CNT_W'(1);
        end else if (w_delete) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    // Response reflects pre-op state; all fields return to zero between pulses.
    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            r_rsp_valid     <= 1'b0;
            r_rsp_hit       <= 1'b0;
            r_rsp_data      <= '0;
            r_rsp_evict     <= 1'b0;
            r_rsp_evict_key <= '0;
        end else begin
            r_rsp_valid     <= 1'b0;
            r_rsp_hit       <= 1'b0;
            r_rsp_data      <= '0;
            r_rsp_evict     <= 1'b0;
            r_rsp_evict_key <= '0;
            if (w_flush_last) begin
                r_rsp_valid <= 1'b1;
            end else if (w_accept && (req_op >= c_OP_READ) && (req_op <= c_OP_DELETE)) begin
                r_rsp_valid     <= 1'b1;
                r_rsp_hit       <= w_hit;
                r_rsp_data      <= w_hit_data;
                r_rsp_evict     <= w_evict;
                r_rsp_evict_key <= w_evict ? r_key[w_victim_idx] : '0;
            end
        end
    end

    assign rsp_valid     = r_rsp_valid;
    assign rsp_hit       = r_rsp_hit;
    assign rsp_data      = r_rsp_data;
    assign rsp_evict     = r_rsp_evict;
    assign rsp_evict_key = r_rsp_evict_key;
    assign count         = r_count;

endmodule
`default_nettype wire
